// File: rtl/regfile_bypass_if.sv
// Register-file access bundle: two read ports, one write port and the control-error flag.
// The master drives selects and write data; the slave (register file) returns read data and err.
interface regfile_bypass_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  read1regsel;
    logic [SELW-1:0]  read2regsel;
    logic [SELW-1:0]  writeregsel;
    logic [WIDTH-1:0] writedata;
    logic             write;
    logic [WIDTH-1:0] read1data;
    logic [WIDTH-1:0] read2data;
    logic             err;

    modport master (
        output read1regsel, read2regsel, writeregsel, writedata, write,
        input  read1data, read2data, err
    );

    modport slave (
        input  read1regsel, read2regsel, writeregsel, writedata, write,
        output read1data, read2data, err
    );
endinterface

// File: rtl/regfile_bypass.sv
// NREG x WIDTH register file with two combinational mux2_1-tree read ports, one synchronous
// write port, optional same-cycle write-to-read forwarding and an X/Z control-input flag.
module regfile_bypass #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 8,
    parameter int SELW   = 3,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_bypass_if.slave  bus
);

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] tree1;
    logic [WIDTH-1:0] tree2;
    logic             hit1;
    logic             hit2;

    function automatic logic [WIDTH-1:0] mux2_1(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sel
    );
        return sel ? b : a;
    endfunction

    // Level 0 is steered by sel[0]; each level halves the surviving candidates in place.
    function automatic logic [WIDTH-1:0] read_tree(
        input logic [WIDTH-1:0] leaves [NREG],
        input logic [SELW-1:0]  sel
    );
        logic [WIDTH-1:0] node [NREG];
        node = leaves;
        for (int lvl = 0; lvl < SELW; lvl++) begin
            for (int i = 0; i < (NREG >> (lvl + 1)); i++) begin
                node[i] = mux2_1(node[2*i], node[2*i+1], sel[lvl]);
            end
        end
        return node[0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write) begin
            regs[bus.writeregsel] <= bus.writedata;
        end
    end

    assign tree1 = read_tree(regs, bus.read1regsel);
    assign tree2 = read_tree(regs, bus.read2regsel);

    // Forwarding is suppressed under reset because that edge discards the write.
    assign hit1 = (BYPASS != 0) && bus.write && !rst && (bus.writeregsel == bus.read1regsel);
    assign hit2 = (BYPASS != 0) && bus.write && !rst && (bus.writeregsel == bus.read2regsel);

    assign bus.read1data = hit1 ? bus.writedata : tree1;
    assign bus.read2data = hit2 ? bus.writedata : tree2;

    assign bus.err = !rst && $isunknown({bus.write, bus.writeregsel,
                                         bus.read1regsel, bus.read2regsel});

endmodule

// File: tb/tb_regfile_bypass.sv
// Scoreboard bench for regfile_bypass: a forwarding and a non-forwarding instance share every
// stimulus; expectations come from a behavioural register model and are queued per cycle.
module tb_regfile_bypass;
    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int SELW  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_bypass_if #(.WIDTH(WIDTH), .SELW(SELW)) bus_b ();
    regfile_bypass_if #(.WIDTH(WIDTH), .SELW(SELW)) bus_n ();

    regfile_bypass #(.WIDTH(WIDTH), .NREG(NREG), .SELW(SELW), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );
    regfile_bypass #(.WIDTH(WIDTH), .NREG(NREG), .SELW(SELW), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n.slave)
    );

    typedef struct {
        logic [WIDTH-1:0] r1b, r2b, r1n, r2n;
        logic             e;
        bit               chk_data;
    } exp_t;

    exp_t             sbq[$];
    logic [WIDTH-1:0] model [NREG];
    int               checks = 0;
    int               errors = 0;

    logic             cur_rst, cur_w;
    logic [SELW-1:0]  cur_ws, cur_s1, cur_s2;
    logic [WIDTH-1:0] cur_wd;

    task automatic drive(input logic r, input logic w, input logic [SELW-1:0] ws,
                         input logic [WIDTH-1:0] wd, input logic [SELW-1:0] s1,
                         input logic [SELW-1:0] s2);
        cur_rst = r; cur_w = w; cur_ws = ws; cur_wd = wd; cur_s1 = s1; cur_s2 = s2;
        rst = r;
        bus_b.write = w; bus_b.writeregsel = ws; bus_b.writedata = wd;
        bus_b.read1regsel = s1; bus_b.read2regsel = s2;
        bus_n.write = w; bus_n.writeregsel = ws; bus_n.writedata = wd;
        bus_n.read1regsel = s1; bus_n.read2regsel = s2;
    endtask

    task automatic push_expect(input bit chk_data);
        exp_t e;
        logic fwd1, fwd2;
        e.chk_data = chk_data;
        e.r1n = model[cur_s1];
        e.r2n = model[cur_s2];
        fwd1 = (cur_w === 1'b1) && (cur_rst === 1'b0) && (cur_ws === cur_s1);
        fwd2 = (cur_w === 1'b1) && (cur_rst === 1'b0) && (cur_ws === cur_s2);
        e.r1b = fwd1 ? cur_wd : e.r1n;
        e.r2b = fwd2 ? cur_wd : e.r2n;
        e.e = (cur_rst === 1'b0) && $isunknown({cur_w, cur_ws, cur_s1, cur_s2});
        sbq.push_back(e);
    endtask

    // Advance one rising edge and apply the same update to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (cur_rst === 1'b1) begin
            for (int i = 0; i < NREG; i++) model[i] = '0;
        end else if (cur_w === 1'b1) begin
            model[cur_ws] = cur_wd;
        end
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        clock_edge();
        for (int r = 0; r < NREG; r++) begin
            drive(1'b0, 1'b1, SELW'(r), WIDTH'($urandom), '0, '0);
            clock_edge();
        end
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        clock_edge();
        for (int s = 0; s < NREG; s++) begin
            drive(1'b0, 1'b0, '0, '0, SELW'(s), SELW'(NREG - 1 - s));
            push_expect(1'b1);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b || bus_n.read1data !== e.r1n ||
                bus_n.read2data !== e.r2n || bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL reset_sweep s=%0d: got %h %h %h %h err %b, required %h %h %h %h err %b",
                         s, bus_b.read1data, bus_b.read2data, bus_n.read1data, bus_n.read2data,
                         bus_b.err, e.r1b, e.r2b, e.r1n, e.r2n, e.e);
            end
            clock_edge();
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int step = 0; step < 2 * NREG; step++) begin
            if (step < NREG)
                drive(1'b0, 1'b1, SELW'(step), WIDTH'(16'h1111 * step), SELW'(step), SELW'(step + 1));
            else
                drive(1'b0, 1'b0, '0, '0, SELW'(step - NREG), SELW'(step - NREG));
            push_expect(1'b1);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b || bus_n.read1data !== e.r1n ||
                bus_n.read2data !== e.r2n || bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL write_read step=%0d: got %h %h %h %h err %b, required %h %h %h %h err %b",
                         step, bus_b.read1data, bus_b.read2data, bus_n.read1data, bus_n.read2data,
                         bus_b.err, e.r1b, e.r2b, e.r1n, e.r2n, e.e);
            end
            clock_edge();
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int step = 0; step < 2; step++) begin
            drive(1'b0, (step == 0), 3'd5, 16'hBEEF, 3'd5, 3'd4);
            push_expect(1'b1);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b || bus_n.read1data !== e.r1n ||
                bus_n.read2data !== e.r2n || bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL bypass step=%0d: got %h %h %h %h err %b, required %h %h %h %h err %b",
                         step, bus_b.read1data, bus_b.read2data, bus_n.read1data, bus_n.read2data,
                         bus_b.err, e.r1b, e.r2b, e.r1n, e.r2n, e.e);
            end
            clock_edge();
        end
    endtask

    task automatic test_reset_during_write();
        exp_t e;
        for (int step = 0; step < 2; step++) begin
            drive((step == 0), (step == 0), 3'd3, 16'hFFFF, 3'd3, 3'd0);
            push_expect(1'b1);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b || bus_n.read1data !== e.r1n ||
                bus_n.read2data !== e.r2n || bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL reset_write step=%0d: got %h %h %h %h err %b, required %h %h %h %h err %b",
                         step, bus_b.read1data, bus_b.read2data, bus_n.read1data, bus_n.read2data,
                         bus_b.err, e.r1b, e.r2b, e.r1n, e.r2n, e.e);
            end
            clock_edge();
        end
        test_reset();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic             w_tab  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] wd_tab [7] = '{16'h2222, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                                         16'h0001, 16'h0002, 16'h0000};
        for (int step = 0; step < 7; step++) begin
            drive(1'b0, w_tab[step], 3'd2, wd_tab[step], 3'd2, 3'd0);
            push_expect(1'b1);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b || bus_n.read1data !== e.r1n ||
                bus_n.read2data !== e.r2n || bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL back_to_back step=%0d: got %h %h %h %h err %b, required %h %h %h %h err %b",
                         step, bus_b.read1data, bus_b.read2data, bus_n.read1data, bus_n.read2data,
                         bus_b.err, e.r1b, e.r2b, e.r1n, e.r2n, e.e);
            end
            clock_edge();
        end
    endtask

    task automatic test_err();
        exp_t e;
        logic            rst_tab [3] = '{1'b0, 1'b0, 1'b1};
        logic [SELW-1:0] sel_tab [3] = '{3'bx1x, 3'd3, 3'bx1x};
        bit              chk_tab [3] = '{1'b0, 1'b1, 1'b0};
        for (int step = 0; step < 3; step++) begin
            drive(rst_tab[step], 1'b0, 3'd0, 16'h0000, sel_tab[step], 3'd1);
            push_expect(chk_tab[step]);
            @(negedge clk);
            e = sbq.pop_front();
            checks++;
            if ((e.chk_data && (bus_b.read1data !== e.r1b || bus_b.read2data !== e.r2b ||
                 bus_n.read1data !== e.r1n || bus_n.read2data !== e.r2n)) ||
                bus_b.err !== e.e || bus_n.err !== e.e) begin
                errors++;
                $display("FAIL err_flag step=%0d: got %h %h err %b/%b, required %h %h err %b",
                         step, bus_b.read1data, bus_b.read2data, bus_b.err, bus_n.err,
                         e.r1b, e.r2b, e.e);
            end
            clock_edge();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_reset_during_write();
        test_back_to_back();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
